minimax_dma: RTL and testbench

Word-granular data-bus initiator (copy/fill engine) for minimax systems. Drives the same data-bus protocol as the minimax core: `addr`, `wdata`, `wmask`, `rreq` out; `rdata`, `rack` in. It copies or fills memory without CPU involvement, and sits on a bus port whose responder is RAM or a memory-mapped peripheral (e.g. the 0xFFFFFFF8 console port). A command port takes one transfer at a time and reports completion, timeout and abort.

---
 rtl/minimax_dma.sv | 163 ++++++++++++++++
 tb/tb_minimax_dma.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/minimax_dma.sv
// minimax_dma: word-granular copy/fill bus initiator for the minimax data bus.
// Latency: first bus cycle the cycle after start; fill 1 cycle/word, copy 2+k cycles/word (k = rack delay).
// Backpressure: stalls in RWAIT until rack; gives up after ACK_TIMEOUT cycles with error set.
// Ports:
//   command : start, mode (0 copy / 1 fill), src, dst, len, fill_value, abort
//   status  : busy, done (1-cycle pulse), error (sticky until next start), words_left
//   bus     : addr, wdata, wmask, rreq out; rdata, rack in
module minimax_dma #(
  parameter int LEN_BITS    = 16,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                mode,
  input  logic [31:0]         src,
  input  logic [31:0]         dst,
  input  logic [LEN_BITS-1:0] len,
  input  logic [31:0]         fill_value,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [LEN_BITS-1:0] words_left,
  output logic [31:0]         addr,
  output logic [31:0]         wdata,
  output logic [3:0]          wmask,
  output logic                rreq,
  input  logic [31:0]         rdata,
  input  logic                rack
);

  localparam logic [7:0]          TMO = 8'(ACK_TIMEOUT);
  localparam logic [LEN_BITS-1:0] ONE = LEN_BITS'(1);

  typedef enum logic [2:0] {S_IDLE, S_RREQ, S_RWAIT, S_WRITE, S_FIN} state_t;

  state_t              state, state_nxt;
  logic [31:0]         src_q, src_nxt, dst_q, dst_nxt, data_q, data_nxt;
  logic [LEN_BITS-1:0] left_nxt;
  logic                mode_q, mode_nxt;
  logic [7:0]          cnt_q, cnt_nxt;
  logic                error_nxt;

  // Next values of the registered outputs.
  logic        busy_d, done_d, rreq_d;
  logic [3:0]  wmask_d;
  logic [31:0] addr_d, wdata_d;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and datapath next values
  always_comb begin
    state_nxt = state;
    src_nxt   = src_q;
    dst_nxt   = dst_q;
    data_nxt  = data_q;
    left_nxt  = words_left;
    mode_nxt  = mode_q;
    cnt_nxt   = cnt_q;
    error_nxt = error;
    case (state)
      S_IDLE: begin
        if (start) begin
          src_nxt   = {src[31:2], 2'b00};
          dst_nxt   = {dst[31:2], 2'b00};
          left_nxt  = len;
          mode_nxt  = mode;
          // In fill mode data_q simply holds the fill word for the whole run.
          data_nxt  = fill_value;
          error_nxt = 1'b0;
          if (len == '0)  state_nxt = S_FIN;
          else if (mode)  state_nxt = S_WRITE;
          else            state_nxt = S_RREQ;
        end
      end
      S_RREQ: begin
        state_nxt = S_RWAIT;
        cnt_nxt   = TMO;
      end
      S_RWAIT: begin
        if (rack) begin
          data_nxt  = rdata;
          state_nxt = S_WRITE;
        end else begin
          cnt_nxt = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            error_nxt = 1'b1;
            state_nxt = S_FIN;
          end
        end
      end
      S_WRITE: begin
        src_nxt  = src_q + 32'd4;
        dst_nxt  = dst_q + 32'd4;
        left_nxt = words_left - ONE;
        if (words_left == ONE) state_nxt = S_FIN;
        else if (mode_q)       state_nxt = S_WRITE;
        else                   state_nxt = S_RREQ;
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // Abort overrides any pending completion or timeout; error keeps its value.
    if (abort && state != S_IDLE) begin
      state_nxt = S_IDLE;
      error_nxt = error;
    end
  end

  // Output decode from the next state so every output leaves a flop.
  always_comb begin
    busy_d  = (state_nxt != S_IDLE);
    done_d  = (state_nxt == S_FIN);
    rreq_d  = (state_nxt == S_RREQ);
    wmask_d = (state_nxt == S_WRITE) ? 4'hF : 4'h0;
    addr_d  = addr;
    wdata_d = wdata;
    if (state_nxt == S_RREQ) begin
      addr_d = src_nxt;
    end else if (state_nxt == S_WRITE) begin
      addr_d  = dst_nxt;
      wdata_d = data_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q      <= '0;
      dst_q      <= '0;
      data_q     <= '0;
      mode_q     <= 1'b0;
      cnt_q      <= '0;
      error      <= 1'b0;
      words_left <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rreq       <= 1'b0;
      wmask      <= 4'h0;
      addr       <= '0;
      wdata      <= '0;
    end else begin
      src_q      <= src_nxt;
      dst_q      <= dst_nxt;
      data_q     <= data_nxt;
      mode_q     <= mode_nxt;
      cnt_q      <= cnt_nxt;
      error      <= error_nxt;
      words_left <= left_nxt;
      busy       <= busy_d;
      done       <= done_d;
      rreq       <= rreq_d;
      wmask      <= wmask_d;
      addr       <= addr_d;
      wdata      <= wdata_d;
    end
  end

endmodule

// File: tb/tb_minimax_dma.sv
// tb_minimax_dma: table-driven bench for minimax_dma with a bus responder model
// and a scoreboard of expected read addresses and expected writes.
`timescale 1ns/1ps
module tb_minimax_dma;
  localparam int LB = 16;

  logic          clk = 1'b0;
  logic          reset, start, mode, abort, rack;
  logic [31:0]   src, dst, fill_value, rdata;
  logic [LB-1:0] len;
  logic          busy, done, error, rreq;
  logic [LB-1:0] words_left;
  logic [31:0]   addr, wdata;
  logic [3:0]    wmask;

  always #5 clk = ~clk;

  minimax_dma #(.LEN_BITS(LB), .ACK_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .src(src), .dst(dst),
    .len(len), .fill_value(fill_value), .abort(abort), .busy(busy), .done(done),
    .error(error), .words_left(words_left), .addr(addr), .wdata(wdata),
    .wmask(wmask), .rreq(rreq), .rdata(rdata), .rack(rack)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } bus_t;

  typedef struct {
    logic        mode;
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] fill;
    int          len;
    int          ack_lat;   // 0 = responder never acks
    int          exp_cyc;   // cycle (after start edge) in which done is seen
    logic        exp_err;
    int          exp_left;
    logic        collide;   // pulse a second start while busy
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  int          ack_lat = 1;
  int          rd_seen = 0;
  int          wr_seen = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] rq [$];
  bus_t        wq [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s: got addr %h expected no bus cycle", name, act);
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0;
  endfunction

  // Bus responder and scoreboard: samples DUT at the falling edge.
  initial begin : resp
    int          pend;
    logic [31:0] paddr;
    bus_t        e;
    pend = 0; paddr = '0; rack = 1'b0; rdata = '0;
    forever begin
      @(negedge clk);
      rack = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          rack  = 1'b1;
          rdata = rd(paddr);
        end
      end
      if (rreq) begin
        rd_seen++;
        if (rq.size() == 0) flag("unexpected_rreq", addr);
        else chk("rreq_addr", addr, rq.pop_front());
        if (ack_lat > 0) begin
          pend  = ack_lat;
          paddr = addr;
        end
      end
      if (wmask != 4'h0) begin
        wr_seen++;
        chk("wmask_full", 32'(wmask), 32'hF);
        if (wq.size() == 0) flag("unexpected_write", addr);
        else begin
          e = wq.pop_front();
          chk("write_addr", addr, e.a);
          chk("write_data", wdata, e.d);
        end
        mem[addr] = wdata;
      end
    end
  end

  task automatic run(input vec_t v);
    logic [31:0] a, d;
    int          got;
    a = {v.src[31:2], 2'b00};
    d = {v.dst[31:2], 2'b00};
    if (v.mode) begin
      for (int i = 0; i < v.len; i++) wq.push_back({d + 32'(4 * i), v.fill});
    end else if (v.len > 0) begin
      if (v.ack_lat == 0) rq.push_back(a);
      else begin
        for (int i = 0; i < v.len; i++) begin
          rq.push_back(a + 32'(4 * i));
          wq.push_back({d + 32'(4 * i), rd(a + 32'(4 * i))});
        end
      end
    end
    ack_lat = v.ack_lat;
    @(negedge clk);
    start = 1'b1; mode = v.mode; src = v.src; dst = v.dst;
    len = LB'(v.len); fill_value = v.fill;
    got = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 1) begin
        chk("busy_rise", 32'(busy), 32'h1);
        chk("error_cleared", 32'(error), 32'h0);
      end
      if (v.collide && i == 2) begin
        start = 1'b1; mode = 1'b0; src = 32'h200; dst = 32'h900; len = LB'(1);
      end
      if (done) begin
        got = i;
        break;
      end
    end
    chk("done_cycle", 32'(got), 32'(v.exp_cyc));
    chk("error_at_fin", 32'(error), 32'(v.exp_err));
    chk("words_left_fin", 32'(words_left), 32'(v.exp_left));
    @(negedge clk);
    start = 1'b0;
    chk("busy_fall", 32'(busy), 32'h0);
    chk("done_one_cycle", 32'(done), 32'h0);
    chk("reads_drained", 32'(rq.size()), 32'h0);
    chk("writes_drained", 32'(wq.size()), 32'h0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_error"}, 32'(error), 32'h0);
    chk({tag, "_words_left"}, 32'(words_left), 32'h0);
    chk({tag, "_addr"}, addr, 32'h0);
    chk({tag, "_wdata"}, wdata, 32'h0);
    chk({tag, "_wmask"}, 32'(wmask), 32'h0);
    chk({tag, "_rreq"}, 32'(rreq), 32'h0);
  endtask

  initial begin : main
    vec_t tbl [8];
    vec_t post;
    int   got, rd0, wr0;
    reset = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0;
    src = '0; dst = '0; len = '0; fill_value = '0;
    for (int i = 0; i < 4; i++) mem[32'h200 + 32'(4 * i)] = 32'hC0DE0000 + 32'(i * 17 + 3);

    //            mode  src           dst           fill          len lat cyc err left coll
    tbl[0] = '{1'b1, 32'h0,        32'h100,      32'hDEADBEEF, 4, 1, 5,  1'b0, 0, 1'b0};
    tbl[1] = '{1'b0, 32'h200,      32'h300,      32'h0,        3, 1, 10, 1'b0, 0, 1'b0};
    tbl[2] = '{1'b0, 32'h203,      32'h300,      32'h0,        0, 1, 1,  1'b0, 0, 1'b0};
    tbl[3] = '{1'b0, 32'h203,      32'h402,      32'h0,        2, 1, 7,  1'b0, 0, 1'b0};
    tbl[4] = '{1'b0, 32'h208,      32'h800,      32'h0,        2, 3, 11, 1'b0, 0, 1'b0};
    tbl[5] = '{1'b0, 32'h200,      32'h700,      32'h0,        2, 0, 17, 1'b1, 2, 1'b0};
    tbl[6] = '{1'b1, 32'h0,        32'hFFFFFFF8, 32'h12345678, 3, 1, 4,  1'b0, 0, 1'b0};
    tbl[7] = '{1'b1, 32'h0,        32'h600,      32'h55AA55AA, 4, 1, 5,  1'b0, 0, 1'b1};

    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b0;

    for (int t = 0; t < 8; t++) run(tbl[t]);

    // Abort in RWAIT of word 2 of 4; the late ack must be ignored.
    rd0 = rd_seen; wr0 = wr_seen;
    rq.push_back(32'h200); rq.push_back(32'h204);
    wq.push_back({32'h500, rd(32'h200)});
    ack_lat = 5;
    @(negedge clk);
    start = 1'b1; mode = 1'b0; src = 32'h200; dst = 32'h500; len = LB'(4);
    got = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) got = 1;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'h0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    chk("abort_no_done", 32'(got), 32'h0);
    chk("abort_error_kept", 32'(error), 32'h0);
    chk("abort_reads", 32'(rd_seen - rd0), 32'h2);
    chk("abort_writes", 32'(wr_seen - wr0), 32'h1);
    chk("abort_reads_drained", 32'(rq.size()), 32'h0);

    post = '{1'b1, 32'h0, 32'hA00, 32'h0BADF00D, 2, 1, 3, 1'b0, 0, 1'b0};
    run(post);

    // Reset while the second word's RREQ is on the bus.
    ack_lat = 1;
    rq.push_back(32'h200); rq.push_back(32'h204);
    wq.push_back({32'hB00, rd(32'h200)});
    @(negedge clk);
    start = 1'b1; mode = 1'b0; src = 32'h200; dst = 32'hB00; len = LB'(3);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("midreset");
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("midreset_idle", 32'(busy), 32'h0);
    chk("midreset_reads_drained", 32'(rq.size()), 32'h0);
    chk("midreset_writes_drained", 32'(wq.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
